// File: rtl/phy_pkg.sv
// Shared PHY framing definitions.
// Contents: 8b/10b control-character codes, idle/SOF word patterns with their
// K masks, rx FSM state encoding, and the keep-vector helper for partial
// final beats.
package phy_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;  // comma
  localparam logic [7:0]  K27_7     = 8'hFB;  // start of frame
  localparam logic [7:0]  K29_7     = 8'hFD;  // end of frame
  localparam logic [7:0]  PAD       = 8'h50;

  localparam logic [31:0] IDLE_WORD = {PAD, PAD, PAD, K28_5};
  localparam logic [31:0] SOF_WORD  = {PAD, PAD, PAD, K27_7};
  localparam logic [3:0]  CTRL_K    = 4'b0001;

  localparam logic [1:0]  ST_ALIGN  = 2'd0;
  localparam logic [1:0]  ST_IDLE   = 2'd1;
  localparam logic [1:0]  ST_DATA   = 2'd2;

  // MSB-aligned AXI keep for n valid bytes (n = 1..3); anything else is a full word.
  function automatic logic [3:0] keep_from_lanes(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/phy_rx_align.sv
// Byte-lane aligner for the rx path.
// Registers the raw GT word, keeps the upper lanes of the previous word and
// rebuilds the aligned word for the latched lane offset. The comma search
// runs on the raw (unregistered) input so the lock counter sees each word on
// the edge that samples it.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_data, i_charisk     raw decoded word and per-lane K flags
//   i_lane_load, i_lane   latch a new lane offset
//   o_comma_vld/_lane     comma found in the raw input, and its lowest lane
//   o_lane                currently latched offset
//   o_data, o_charisk     aligned word and K flags (lane0 = first wire byte)
module phy_rx_align
  import phy_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_charisk,
  input  logic        i_lane_load,
  input  logic [1:0]  i_lane,
  output logic        o_comma_vld,
  output logic [1:0]  o_comma_lane,
  output logic [1:0]  o_lane,
  output logic [31:0] o_data,
  output logic [3:0]  o_charisk
);

  logic [31:0] cur_q, cur_d;
  logic [3:0]  curk_q, curk_d;
  // lane 0 of the previous word is never needed, so it is not stored
  logic [31:8] prev_q, prev_d;
  logic [3:1]  prevk_q, prevk_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    cur_d   = i_data;
    curk_d  = i_charisk;
    prev_d  = cur_q[31:8];
    prevk_d = curk_q[3:1];
    lane_d  = i_lane_load ? i_lane : lane_q;
  end

  always_comb begin
    o_comma_vld  = 1'b0;
    o_comma_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_charisk[i] && (i_data[8*i +: 8] == K28_5)) begin
        o_comma_vld  = 1'b1;
        o_comma_lane = 2'(i);
      end
    end
  end

  // aligned = prev[L..3] followed by cur[0..L-1]
  always_comb begin
    case (lane_q)
      2'd1: begin
        o_data    = {cur_q[7:0], prev_q[31:8]};
        o_charisk = {curk_q[0], prevk_q[3:1]};
      end
      2'd2: begin
        o_data    = {cur_q[15:0], prev_q[31:16]};
        o_charisk = {curk_q[1:0], prevk_q[3:2]};
      end
      2'd3: begin
        o_data    = {cur_q[23:0], prev_q[31:24]};
        o_charisk = {curk_q[2:0], prevk_q[3]};
      end
      default: begin
        o_data    = cur_q;
        o_charisk = curk_q;
      end
    endcase
  end

  assign o_lane = lane_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_q   <= '0;
      curk_q  <= '0;
      prev_q  <= '0;
      prevk_q <= '0;
      lane_q  <= '0;
    end else begin
      cur_q   <= cur_d;
      curk_q  <= curk_d;
      prev_q  <= prev_d;
      prevk_q <= prevk_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/phy_rx.sv
// Receive framing stage: comma lock, SOF/EOF stripping, AXI-Stream master.
// Ports:
//   i_clk, i_rst_n                 GT rx user clock, async active-low reset
//   i_gt_rx_done                   GT rx ready; low forces re-alignment
//   i_gt_rx_data, i_gt_rx_charisk  decoded word (lane0 first on wire), K flags
//   o_axi_m_*                      AXI-Stream beat (no backpressure)
//   o_rx_aligned                   lane alignment locked
//
// state | meaning
// ALIGN | counting consecutive commas in one lane
// IDLE  | locked, waiting for SOF
// DATA  | inside a frame, payload goes through the hold register
module phy_rx
  import phy_pkg::*;
#(
  parameter int P_ALIGN_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_gt_rx_done,
  input  logic [31:0] i_gt_rx_data,
  input  logic [3:0]  i_gt_rx_charisk,
  output logic        o_axi_m_valid,
  output logic [31:0] o_axi_m_data,
  output logic [3:0]  o_axi_m_keep,
  output logic        o_axi_m_last,
  output logic        o_axi_m_user,
  output logic        o_rx_aligned
);

  localparam int              CNT_W    = $clog2(P_ALIGN_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(P_ALIGN_CNT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cnt_lane_q, cnt_lane_d;
  logic             aligned_q, aligned_d;
  logic             hold_v_q, hold_v_d;
  logic             hold_last_q, hold_last_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic [3:0]       hold_keep_q, hold_keep_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       keep_q, keep_d;
  logic             last_q, last_d;
  logic             user_q, user_d;

  logic        lane_load, comma_vld;
  logic [1:0]  comma_lane, lane;
  logic [31:0] al_data, al_axi, eof_mask;
  logic [3:0]  al_k, eof_keep;
  logic        eof_found, eof_hit;
  logic [1:0]  eof_lane;
  logic        emit, emit_last, emit_user;

  phy_rx_align u_align (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_gt_rx_data),
    .i_charisk    (i_gt_rx_charisk),
    .i_lane_load  (lane_load),
    .i_lane       (comma_lane),
    .o_comma_vld  (comma_vld),
    .o_comma_lane (comma_lane),
    .o_lane       (lane),
    .o_data       (al_data),
    .o_charisk    (al_k)
  );

  assign al_axi = {al_data[7:0], al_data[15:8], al_data[23:16], al_data[31:24]};

  // The lowest K lane decides: FD there is EOF, any other K char is corruption.
  always_comb begin
    eof_found = 1'b0;
    eof_hit   = 1'b0;
    eof_lane  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!eof_found && al_k[i]) begin
        eof_found = 1'b1;
        eof_hit   = (al_data[8*i +: 8] == K29_7);
        eof_lane  = 2'(i);
      end
    end
  end

  assign eof_keep = keep_from_lanes({1'b0, eof_lane});
  assign eof_mask = {{8{eof_keep[3]}}, {8{eof_keep[2]}}, {8{eof_keep[1]}}, {8{eof_keep[0]}}};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_lane_d  = cnt_lane_q;
    aligned_d   = aligned_q;
    hold_v_d    = hold_v_q;
    hold_last_d = hold_last_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    lane_load   = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_user   = 1'b0;

    // A partial final word parked by EOF drains on the next cycle,
    // whatever the FSM does with the current word.
    if (hold_v_q && hold_last_q) begin
      emit        = 1'b1;
      emit_last   = 1'b1;
      hold_v_d    = 1'b0;
      hold_last_d = 1'b0;
    end

    case (state_q)
      ST_ALIGN: begin
        if (!i_gt_rx_done) begin
          cnt_d = '0;
        end else if (comma_vld) begin
          cnt_lane_d = comma_lane;
          if ((cnt_q != '0) && (comma_lane == cnt_lane_q)) cnt_d = cnt_q + CNT_W'(1);
          else                                              cnt_d = CNT_W'(1);
          if (cnt_d == CNT_LOCK) begin
            lane_load = 1'b1;
            aligned_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      ST_IDLE: begin
        if (!i_gt_rx_done) begin
          aligned_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_ALIGN;
        end else if (comma_vld && (comma_lane != lane)) begin
          // this comma already counts as the first of the new lock attempt
          aligned_d  = 1'b0;
          cnt_d      = CNT_W'(1);
          cnt_lane_d = comma_lane;
          state_d    = ST_ALIGN;
        end else if ((al_data == SOF_WORD) && (al_k == CTRL_K)) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!i_gt_rx_done) begin
          emit        = hold_v_q;
          emit_last   = 1'b1;
          emit_user   = 1'b1;
          hold_v_d    = 1'b0;
          hold_last_d = 1'b0;
          aligned_d   = 1'b0;
          cnt_d       = '0;
          state_d     = ST_ALIGN;
        end else if (al_k == 4'b0000) begin
          emit        = hold_v_q;
          hold_v_d    = 1'b1;
          hold_last_d = 1'b0;
          hold_data_d = al_axi;
          hold_keep_d = 4'b1111;
        end else if (eof_hit) begin
          if (eof_lane == 2'd0) begin
            emit      = hold_v_q;
            emit_last = 1'b1;
            hold_v_d  = 1'b0;
          end else begin
            emit        = hold_v_q;
            hold_v_d    = 1'b1;
            hold_last_d = 1'b1;
            hold_data_d = al_axi & eof_mask;
            hold_keep_d = eof_keep;
          end
          state_d = ST_IDLE;
        end else begin
          emit        = hold_v_q;
          emit_last   = 1'b1;
          emit_user   = 1'b1;
          hold_v_d    = 1'b0;
          hold_last_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_ALIGN;
    endcase

    valid_d = emit;
    data_d  = emit ? hold_data_q : '0;
    keep_d  = emit ? hold_keep_q : '0;
    last_d  = emit & emit_last;
    user_d  = emit & emit_user;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_ALIGN;
      cnt_q       <= '0;
      cnt_lane_q  <= '0;
      aligned_q   <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cnt_lane_q  <= cnt_lane_d;
      aligned_q   <= aligned_d;
      hold_v_q    <= hold_v_d;
      hold_last_q <= hold_last_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      user_q      <= user_d;
    end
  end

  assign o_axi_m_valid = valid_q;
  assign o_axi_m_data  = data_q;
  assign o_axi_m_keep  = keep_q;
  assign o_axi_m_last  = last_q;
  assign o_axi_m_user  = user_q;
  assign o_rx_aligned  = aligned_q;

endmodule

// File: tb/tb_phy_rx.sv
// Scoreboard bench for phy_rx: stimulus pushes expected beats, a monitor
// pops and compares whenever o_axi_m_valid is seen.
module tb_phy_rx;
  import phy_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_gt_rx_done;
  logic [31:0] i_gt_rx_data;
  logic [3:0]  i_gt_rx_charisk;
  logic        o_axi_m_valid;
  logic [31:0] o_axi_m_data;
  logic [3:0]  o_axi_m_keep;
  logic        o_axi_m_last;
  logic        o_axi_m_user;
  logic        o_rx_aligned;

  phy_rx dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_gt_rx_done    (i_gt_rx_done),
    .i_gt_rx_data    (i_gt_rx_data),
    .i_gt_rx_charisk (i_gt_rx_charisk),
    .o_axi_m_valid   (o_axi_m_valid),
    .o_axi_m_data    (o_axi_m_data),
    .o_axi_m_keep    (o_axi_m_keep),
    .o_axi_m_last    (o_axi_m_last),
    .o_axi_m_user    (o_axi_m_user),
    .o_rx_aligned    (o_rx_aligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    off    = 0;
  logic [15:0] prev_hi  = 16'h5050;
  logic [1:0]  prevk_hi = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    exp_q.push_back(b);
  endtask

  // Send one aligned word; with off == 2 the wire stream is shifted by two bytes.
  task automatic send_al(input logic [31:0] a, input logic [3:0] ak);
    @(negedge i_clk);
    if (off == 2) begin
      i_gt_rx_data    = {a[15:0], prev_hi};
      i_gt_rx_charisk = {ak[1:0], prevk_hi};
    end else begin
      i_gt_rx_data    = a;
      i_gt_rx_charisk = ak;
    end
    prev_hi  = a[31:16];
    prevk_hi = ak[3:2];
  endtask

  task automatic basic_frame();
    exp_beat(32'h12345678, 4'b1111, 1'b0, 1'b0);
    exp_beat(32'h87650000, 4'b1100, 1'b1, 1'b0);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h78563412, 4'b0000);
    send_al(32'h50FD6587, 4'b0100);
  endtask

  // monitor
  initial begin
    beat_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_axi_m_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got data %h keep %b last %b user %b, expected no beat",
                   o_axi_m_data, o_axi_m_keep, o_axi_m_last, o_axi_m_user);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", o_axi_m_data, e.d);
          chk("beat_keep", {28'd0, o_axi_m_keep}, {28'd0, e.k});
          chk("beat_last", {31'd0, o_axi_m_last}, {31'd0, e.l});
          chk("beat_user", {31'd0, o_axi_m_user}, {31'd0, e.u});
        end
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_gt_rx_done = 1'b1; i_gt_rx_data = '0; i_gt_rx_charisk = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_valid",   {31'd0, o_axi_m_valid}, 32'd0);
    chk("rst_data",    o_axi_m_data, 32'd0);
    chk("rst_keep",    {28'd0, o_axi_m_keep}, 32'd0);
    chk("rst_last",    {31'd0, o_axi_m_last}, 32'd0);
    chk("rst_user",    {31'd0, o_axi_m_user}, 32'd0);
    chk("rst_aligned", {31'd0, o_rx_aligned}, 32'd0);
    i_rst_n = 1'b1;

    // lock at L=0
    repeat (3) send_al(IDLE_WORD, CTRL_K);
    send_al(IDLE_WORD, CTRL_K);
    chk("aligned_before_4th", {31'd0, o_rx_aligned}, 32'd0);
    @(posedge i_clk); #1;
    chk("aligned_after_4th", {31'd0, o_rx_aligned}, 32'd1);
    send_al(IDLE_WORD, CTRL_K);

    // basic frame
    basic_frame();
    send_al(IDLE_WORD, CTRL_K);

    // zero payload frame: nothing emitted
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h505050FD, 4'b0001);
    send_al(IDLE_WORD, CTRL_K);

    // word-multiple frame, then SOF right after EOF, ending with EOF in lane 1
    exp_beat(32'h12345678, 4'b1111, 1'b1, 1'b0);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h78563412, 4'b0000);
    send_al(32'h505050FD, 4'b0001);
    exp_beat(32'h11223344, 4'b1111, 1'b0, 1'b0);
    exp_beat(32'h99000000, 4'b1000, 1'b1, 1'b0);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h44332211, 4'b0000);
    send_al(32'h5050FD99, 4'b0010);
    send_al(IDLE_WORD, CTRL_K);

    // corruption: K FB mid-frame, then a clean frame
    exp_beat(32'hAABBCCDD, 4'b1111, 1'b1, 1'b1);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'hDDCCBBAA, 4'b0000);
    send_al(32'h505050FB, 4'b0001);
    send_al(IDLE_WORD, CTRL_K);
    basic_frame();
    repeat (2) send_al(IDLE_WORD, CTRL_K);

    // re-align to L=2
    off = 2;
    send_al(IDLE_WORD, CTRL_K);
    @(posedge i_clk); #1;
    chk("realign_drop", {31'd0, o_rx_aligned}, 32'd0);
    repeat (5) send_al(IDLE_WORD, CTRL_K);
    @(posedge i_clk); #1;
    chk("relock_l2", {31'd0, o_rx_aligned}, 32'd1);
    basic_frame();
    repeat (3) send_al(IDLE_WORD, CTRL_K);

    // loss of link mid-frame (L=2)
    exp_beat(32'hDEADF00D, 4'b1111, 1'b0, 1'b0);
    exp_beat(32'h01020304, 4'b1111, 1'b1, 1'b1);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h0DF0ADDE, 4'b0000);
    send_al(32'h04030201, 4'b0000);
    send_al(32'h11111111, 4'b0000);
    send_al(32'h22222222, 4'b0000);
    @(negedge i_clk);
    i_gt_rx_done = 1'b0; i_gt_rx_data = '0; i_gt_rx_charisk = '0;
    @(posedge i_clk); #1;
    chk("link_loss_aligned", {31'd0, o_rx_aligned}, 32'd0);
    @(negedge i_clk);
    i_gt_rx_done = 1'b1;

    // relock at L=0, then async reset mid-frame
    off = 0;
    repeat (4) send_al(IDLE_WORD, CTRL_K);
    @(posedge i_clk); #1;
    chk("relock_l0", {31'd0, o_rx_aligned}, 32'd1);
    exp_beat(32'h12345678, 4'b1111, 1'b0, 1'b0);
    send_al(SOF_WORD, CTRL_K);
    send_al(32'h78563412, 4'b0000);
    send_al(32'hEFBEAD0B, 4'b0000);
    send_al(32'h33333333, 4'b0000);
    @(posedge i_clk); #1;
    chk("pre_rst_valid", {31'd0, o_axi_m_valid}, 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid",   {31'd0, o_axi_m_valid}, 32'd0);
    chk("async_rst_data",    o_axi_m_data, 32'd0);
    chk("async_rst_keep",    {28'd0, o_axi_m_keep}, 32'd0);
    chk("async_rst_last",    {31'd0, o_axi_m_last}, 32'd0);
    chk("async_rst_aligned", {31'd0, o_rx_aligned}, 32'd0);
    @(negedge i_clk);
    i_gt_rx_data = '0; i_gt_rx_charisk = '0;
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge i_clk);
    repeat (3) @(negedge i_clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phy_rx.md
# phy_rx

Receive-side PHY framing stage, the mirror of `phy_tx`. It takes the raw 32-bit 8b/10b-decoded word and char-K flags from the GT receiver and finds byte-lane alignment from K28.5 commas. It strips the SOF/EOF control framing and presents each frame as an AXI-Stream master (data/keep/last/user) to user logic. There is no backpressure: the GT cannot be stalled.

## Interface
Parameters:
- `P_ALIGN_CNT`, default 4: number of consecutive idle words with a comma in the same lane needed to declare alignment.

Ports:
- `i_clk`, input, 1: GT rx user clock; the only clock.
- `i_rst_n`, input, 1: reset; asynchronous, active-low.
- `i_gt_rx_done`, input, 1: GT rx reset/CDR done. Low forces the ALIGN state.
- `i_gt_rx_data`, input, 32: decoded word; lane0 = [7:0] is the first byte on the wire.
- `i_gt_rx_charisk`, input, 4: per-lane K flag.
- `o_axi_m_valid`, output, 1: beat valid.
- `o_axi_m_data`, output, 32: AXI byte order; first wire byte is in [31:24].
- `o_axi_m_keep`, output, 4: MSB-aligned; one of 1111/1110/1100/1000.
- `o_axi_m_last`, output, 1: last beat of the frame.
- `o_axi_m_user`, output, 1: error flag, valid with last. 1 = frame truncated or corrupt.
- `o_rx_aligned`, output, 1: lane alignment locked.

## Operation
- Control chars, per lane with K=1: `BC` = K28.5 comma, `FB` = K27.7 SOF, `FD` = K29.7 EOF. Pad/idle data byte is `50`.
- Idle word (aligned) is `505050BC` with charisk `0001`. The SOF word is `505050FB` with charisk `0001`.
- **Alignment:** the lane offset L (0..3) is the lane holding a K `BC`.
  - Aligned word = wire bytes prev[L..3] followed by cur[0..L-1], taken from the previous and current input words. L=0 passes cur through.
- **State machine:**
  - ALIGN: count consecutive words whose comma sits in the same lane. When the count reaches `P_ALIGN_CNT`, latch L and go to IDLE with `o_rx_aligned`=1. A comma in a different lane restarts the count at 1.
  - IDLE: aligned SOF word goes to DATA. A comma in a lane other than L goes to ALIGN (`o_rx_aligned`=0). Other words are ignored.
  - DATA: aligned words with charisk `0000` are payload. An aligned word with K `FD` in lane j ends the frame:
    - j=0: the previous payload word is last, keep 1111.
    - j>0: this word is last, keep = j MSB ones. Invalid bytes are output as 0.
    - Then go to IDLE.
  - DATA, SOF with zero payload (FD in lane 0 of the first word): frame discarded, no beats, no error.
- **Byte mapping:** aligned lane k maps to `o_axi_m_data[31-8k -: 8]`.
- **Errors in DATA:** any other K char (including `BC` or `FB`), or `i_gt_rx_done` falling.
  - The held payload word, if any, is emitted with last=1, user=1, keep 1111.
  - If no word is held, nothing is emitted.
  - Then go to IDLE. If `i_gt_rx_done` fell, go to ALIGN instead.
- `o_axi_m_user`=0 on all non-last beats and on clean last beats.

## Timing
- Reset (async assert, sync release):
  - Outputs: `o_axi_m_valid`, `o_axi_m_data`, `o_axi_m_keep`, `o_axi_m_last`, `o_axi_m_user` and `o_rx_aligned` are all 0.
  - Internal: state ALIGN, L=0, align count 0, holding register empty.
- Registered input stage feeds the aligned-word register. A one-word hold register is needed to decide last.
- Latency: a payload word whose final wire byte is sampled at edge k appears on the outputs after edge k+2.
- `o_axi_m_valid` is a registered 1-cycle pulse per beat. Back-to-back beats for back-to-back payload words.
- An SOF may follow EOF on the very next word; the new frame is accepted with no gap.
- `o_rx_aligned` rises on the edge the count reaches `P_ALIGN_CNT` and falls on the edge that leaves IDLE/DATA for ALIGN.
- Reset mid-frame: outputs clear immediately (async) and no partial last is emitted.

## Structure
- Shared package `phy_pkg`:
  - K-char constants `K28_5`=8'hBC, `K27_7`=8'hFB, `K29_7`=8'hFD, `PAD`=8'h50.
  - Idle and SOF word constants.
  - Rx state encoding: ALIGN, IDLE, DATA.
  - Keep-from-lane-count function.
- Sub-module `phy_rx_align`: holds the previous word, searches for the comma, latches L and outputs the aligned data/charisk. `phy_rx` holds the FSM, hold register and AXI output.

## Test plan
- **Lock, L=0:** 4 words of `505050BC`/`0001` after reset → `o_rx_aligned`=1 after the 4th edge; no valid beats.
- **Basic frame:** SOF, then `78563412`/`0000`, then `50FD6587`/`0100` → two beats.
  - Beat 1: `12345678`, keep 1111, last 0.
  - Beat 2: `87650000`, keep 1100, last 1, user 0.
- **Offset L=2:** idle `50BC5050`/`0100` and the same frame shifted by 2 bytes → identical beats to the basic frame.
- **Word-multiple frame:** `78563412`, then an EOF word `505050FD`/`0001` → a single beat `12345678`, keep 1111, last 1.
- **Corruption:** SOF, one payload word, then a K `FB` mid-frame → that word is emitted with last=1 and user=1; next frame is received cleanly.
- **Loss of link:** `i_gt_rx_done` deasserted mid-frame → truncated last with user=1 and `o_rx_aligned`→0. Async `i_rst_n` low mid-frame → all outputs 0 at once.
